// File: rtl/sd_norm_pkg.sv
// Shared defaults for the slot-offset normaliser and the offset-width helper.
package sd_norm_pkg;
   localparam int S_W_DEF       = 11;
   localparam int N_W_DEF       = 4;
   localparam int MAXV_DEF      = 255;
   localparam int N_MAX_DEF     = 8;
   localparam int N_DEFAULT_DEF = 4;
   localparam int CNT_W_DEF     = 16;

   // Bits needed to hold the largest offset n·MAXV.
   function automatic int off_w(input int n_max, input int maxv);
      return $clog2(n_max * maxv + 1);
   endfunction
endpackage

// File: rtl/sd_off_lut.sv
// Combinational nslt -> {offset, clip} table; out-of-range selectors map to N_DEFAULT.
module sd_off_lut
   import sd_norm_pkg::*;
#(
   parameter int N_W       = N_W_DEF,
   parameter int MAXV      = MAXV_DEF,
   parameter int N_MAX     = N_MAX_DEF,
   parameter int N_DEFAULT = N_DEFAULT_DEF,
   parameter int OFF_W     = off_w(N_MAX_DEF, MAXV_DEF)
) (
   input  logic [N_W-1:0]   nslt,
   output logic [OFF_W-1:0] off,
   output logic             nclip
);
   logic [OFF_W-1:0] tbl [2**N_W];

   for (genvar i = 0; i < 2**N_W; i++) begin : g_tbl
      assign tbl[i] = OFF_W'(((i > N_MAX) ? N_DEFAULT : i) * MAXV);
   end

   assign off   = tbl[nslt];
   assign nclip = (nslt > N_W'(N_MAX));
endmodule

// File: rtl/sd_norm_pipe.sv
// Two-stage valid/ready pipeline computing d = s - n_eff*MAXV with wrap or clamp,
// per-beat underflow/clip flags and a saturating underflow event counter.
module sd_norm_pipe
   import sd_norm_pkg::*;
#(
   parameter int S_W       = S_W_DEF,
   parameter int N_W       = N_W_DEF,
   parameter int MAXV      = MAXV_DEF,
   parameter int N_MAX     = N_MAX_DEF,
   parameter int N_DEFAULT = N_DEFAULT_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_W-1:0]   nslt,
   input  logic [S_W-1:0]   s,
   input  logic             sat_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [S_W-1:0]   d,
   output logic             out_uflow,
   output logic             out_nclip,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] uflow_cnt
);
   localparam int OFF_W  = off_w(N_MAX, MAXV);
   localparam int DW     = ((S_W > OFF_W) ? S_W : OFF_W) + 1;
   localparam int STAGES = 2;

   if (N_DEFAULT > N_MAX || N_MAX >= 2**N_W) begin : g_bad_params
      $error("sd_norm_pipe: need N_DEFAULT <= N_MAX < 2**N_W");
   end

   logic [STAGES:1]  vld_pipe;
   logic             ld2;
   logic [OFF_W-1:0] lut_off;
   logic             lut_nclip;

   logic [S_W-1:0]   s1;
   logic [OFF_W-1:0] off1;
   logic             sat1;
   logic             nclip1;
   logic [DW-1:0]    diff;
   logic             uflow;

   sd_off_lut #(
      .N_W      (N_W),
      .MAXV     (MAXV),
      .N_MAX    (N_MAX),
      .N_DEFAULT(N_DEFAULT),
      .OFF_W    (OFF_W)
   ) u_lut (
      .nslt (nslt),
      .off  (lut_off),
      .nclip(lut_nclip)
   );

   assign out_valid = vld_pipe[2];
   assign ld2       = !vld_pipe[2] | out_ready;
   // Stage 1 may also fill while stage 2 is stalled, provided it is empty.
   assign in_ready  = !vld_pipe[1] | ld2;

   // Operands are below 2^(DW-1), so the MSB of the difference is the borrow.
   assign diff  = DW'(s1) - DW'(off1);
   assign uflow = diff[DW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[1] <= 1'b0;
         s1          <= '0;
         off1        <= '0;
         sat1        <= 1'b0;
         nclip1      <= 1'b0;
      end else if (in_ready) begin
         vld_pipe[1] <= in_valid;
         if (in_valid) begin
            s1     <= s;
            off1   <= lut_off;
            sat1   <= sat_mode;
            nclip1 <= lut_nclip;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[2] <= 1'b0;
         d           <= '0;
         out_uflow   <= 1'b0;
         out_nclip   <= 1'b0;
      end else if (ld2) begin
         vld_pipe[2] <= vld_pipe[1];
         if (vld_pipe[1]) begin
            d         <= (uflow & sat1) ? '0 : diff[S_W-1:0];
            out_uflow <= uflow;
            out_nclip <= nclip1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uflow_cnt <= '0;
      end else if (cnt_clr) begin
         uflow_cnt <= '0;
      end else if (out_valid && out_ready && out_uflow && uflow_cnt != '1) begin
         uflow_cnt <= uflow_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_sd_norm_pipe.sv
// Directed bench for sd_norm_pipe: latency, wrap/clamp, clip, backpressure, reset, counter.
module tb_sd_norm_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  nslt;
   logic [10:0] s;
   logic        sat_mode;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] d;
   logic        out_uflow;
   logic        out_nclip;
   logic        cnt_clr;
   logic [15:0] uflow_cnt;

   int checks = 0;
   int errors = 0;

   sd_norm_pipe dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .nslt     (nslt),
      .s        (s),
      .sat_mode (sat_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .d        (d),
      .out_uflow(out_uflow),
      .out_nclip(out_nclip),
      .cnt_clr  (cnt_clr),
      .uflow_cnt(uflow_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One isolated beat: out_valid must be low one cycle after issue, high the next.
   task automatic beat(input int sv, input int nv, input int sm,
                       input int exp_d, input int exp_u, input int exp_c);
      @(negedge clk);
      s = 11'(sv); nslt = 4'(nv); sat_mode = sm[0]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat_cycle1_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(out_valid), 1);
      chk("beat_d", 32'(d), 32'(exp_d));
      chk("beat_uflow", 32'(out_uflow), 32'(exp_u));
      chk("beat_nclip", 32'(out_nclip), 32'(exp_c));
   endtask

   initial begin
      int sent;
      int rx;
      bit leaked;

      rst_n = 1'b0; in_valid = 1'b0; nslt = '0; s = '0; sat_mode = 1'b0;
      out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_d", 32'(d), 0);
      chk("rst_uflow", 32'(out_uflow), 0);
      chk("rst_nclip", 32'(out_nclip), 0);
      chk("rst_cnt", 32'(uflow_cnt), 0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 1);

      beat(1000, 3, 0, 235, 0, 0);
      beat(700, 3, 0, 1983, 1, 0);
      beat(700, 3, 1, 0, 1, 0);
      beat(2047, 12, 0, 1027, 0, 1);
      beat(2040, 8, 0, 0, 0, 0);
      chk("cnt_after_uflows", 32'(uflow_cnt), 2);

      // Backpressure: 5 beats, out_ready low for cycles 3..7.
      sent = 0; rx = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 7);
         in_valid  = (sent < 5);
         s         = 11'(sent + 1);
         nslt      = '0;
         sat_mode  = 1'b0;
         #1;
         if (c == 5) begin
            chk("bp_in_ready_low", 32'(in_ready), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_d5", 32'(d), 2);
         end
         if (c == 7) chk("bp_hold_d7", 32'(d), 2);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            chk("bp_order", 32'(d), 32'(rx + 1));
            rx++;
         end
      end
      in_valid = 1'b0;
      chk("bp_sent", 32'(sent), 5);
      chk("bp_received", 32'(rx), 5);

      // Reset with two beats in flight.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; s = 11'd10; nslt = '0;
      @(negedge clk);
      s = 11'd11;
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_cnt", 32'(uflow_cnt), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_cnt", 32'(uflow_cnt), 0);
      chk("mid_rst_d", 32'(d), 0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1 chk("post_rst_in_ready", 32'(in_ready), 1);
      leaked = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) leaked = 1'b1;
      end
      chk("rst_no_leak", 32'(leaked), 0);

      // Counter saturation with a continuous underflow stream.
      @(negedge clk);
      in_valid = 1'b1; s = '0; nslt = 4'd1; sat_mode = 1'b0; out_ready = 1'b1;
      repeat (65540) @(negedge clk);
      chk("cnt_saturated", 32'(uflow_cnt), 65535);
      repeat (3) @(negedge clk);
      chk("cnt_held", 32'(uflow_cnt), 65535);
      chk("stream_uflow", 32'(out_uflow & out_valid), 1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      chk("cnt_clr_priority", 32'(uflow_cnt), 0);
      @(negedge clk);
      chk("cnt_after_clr", 32'(uflow_cnt), 1);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sd_norm_pipe.md
Name: sd_norm_pipe

Overview:
- Parametrised, pipelined successor to the combinational slot-offset subtractor in the mean-filter feedback path.
- Computes D = s − n_eff·MAXV, where n_eff is the count of contributing samples selected by nslt.
- Adds valid/ready flow control, 2-stage registered datapath, runtime wrap/saturate mode, per-beat underflow and clip flags, and a sticky underflow event counter.
- Sits between the window-sum accumulator and the divide/feedback stage.

Parameters:
- S_W, 11, width of sum input s and result d.
- N_W, 4, width of nslt.
- MAXV, 255, per-sample full-scale value subtracted per selected slot.
- N_MAX, 8, largest legal nslt value.
- N_DEFAULT, 4, n_eff used when nslt > N_MAX.
- CNT_W, 16, width of underflow event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- nslt  in  N_W  slot count selector.
- s  in  S_W  unsigned sum.
- sat_mode  in  1  0 = wrap (modulo 2^S_W), 1 = clamp to 0 on underflow; sampled with each beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- d  out  S_W  result.
- out_uflow  out  1  s < n_eff·MAXV for this beat.
- out_nclip  out  1  nslt > N_MAX for this beat (N_DEFAULT substituted).
- cnt_clr  in  1  synchronous clear of uflow_cnt.
- uflow_cnt  out  CNT_W  count of accepted-out beats with out_uflow = 1, saturating.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all valids 0, d 0, out_uflow 0, out_nclip 0, uflow_cnt 0. In-flight beats are discarded. in_ready is 1 in the first cycle after reset.
- Accept rule: input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready.
- Stage 1 registers on accept:
  - s, sat_mode.
  - nclip = (nslt > N_MAX).
  - off = (nclip ? N_DEFAULT : nslt) · MAXV, with width OFF_W = clog2(N_MAX·MAXV+1).
- Stage 2 registers:
  - diff = {1'b0,s} − off, computed at max(S_W,OFF_W)+1 bits; uflow = borrow.
  - d = (uflow & sat_mode) ? 0 : diff[S_W-1:0].
- Latency: exactly 2 cycles from input accept to out_valid when out_ready stays high. Throughput 1 beat/cycle.
- Stall:
  - stage 2 loads when !out_valid | out_ready.
  - stage 1 advances when stage 2 loads.
  - in_ready = !v1 | !out_valid | out_ready. A combinational path out_ready→in_ready is permitted.
- Holding: while out_valid & !out_ready, d/out_uflow/out_nclip hold stable. No beat is dropped, duplicated or reordered. At most 2 beats are buffered.
- Bubbles: v1 = 0 with stage 2 free makes out_valid fall next cycle.
- Counter:
  - Increments on each output transfer with out_uflow = 1.
  - Saturates at 2^CNT_W − 1.
  - cnt_clr has priority over a same-cycle increment (result 0).
- Elaboration check: compile-time error if N_DEFAULT > N_MAX or N_MAX ≥ 2^N_W.

Decomposition:
- Package sd_norm_pkg holds default constants (S_W, N_W, MAXV, N_MAX, N_DEFAULT) and the OFF_W function.
- One sub-module: sd_off_lut, a combinational nslt → {off, nclip} table generated from the parameters.

Test Plan:
- Wrap, no underflow: s=1000, nslt=3, sat_mode=0, out_ready=1 → d=235, out_uflow=0, out_nclip=0, exactly 2 cycles after accept.
- Underflow, both modes:
  - s=700, nslt=3, sat_mode=0 → d=1983, out_uflow=1.
  - Same beat with sat_mode=1 → d=0, out_uflow=1.
  - uflow_cnt reads 2 afterwards.
- Clip: nslt=12, s=2047 → n_eff=4, d=1027, out_nclip=1. Boundary nslt=8, s=2040 → d=0, out_uflow=0.
- Backpressure:
  - Stimulus: stream 5 beats (nslt=0, s=1..5) with out_ready low for cycles 3–7.
  - in_ready drops after 2 beats are buffered.
  - Outputs arrive as 1..5 in order, no loss; d holds stable while stalled.
- Reset and counter:
  - Assert rst_n mid-stream with 2 beats in flight → out_valid=0 and uflow_cnt=0 immediately; the in-flight beats never appear.
  - Force counter to 2^16−1 with repeated underflows → holds at 65535.
  - cnt_clr together with an underflow transfer → 0.
